// File: rtl/bus_xfer_seq_if.sv
// Command handshake and register strobe lanes between bus_xfer_seq and its environment.
// The sequencer takes the master side; the command source and the bus registers see the slave side.
interface bus_xfer_seq_if #(
   parameter int N_REGS = 4
);
   localparam int SEL_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [SEL_W-1:0]  cmd_src;
   logic [SEL_W-1:0]  cmd_dst;
   logic [7:0]        cmd_imm;
   logic [N_REGS-1:0] rd_en;
   logic [N_REGS-1:0] wr_en;
   logic [N_REGS-1:0] clr;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
      output cmd_ready, rd_en, wr_en, clr, busy, done, err
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
      input  cmd_ready, rd_en, wr_en, clr, busy, done, err
   );
endinterface

// File: rtl/bus_xfer_seq.sv
// Bus initiator: queues transfer commands and sequences one-cycle register strobes
// (IDLE -> EXEC -> TURN) on the shared 8-bit bus, driving immediates during LOADI.
module bus_xfer_seq #(
   parameter int N_REGS     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              clr_n,
   bus_xfer_seq_if.master    ifc,
   output wire  [7:0]        bus_out
);
   localparam int SEL_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_MOVE  = 2'b01;
   localparam logic [1:0] OP_LOADI = 2'b10;
   localparam logic [1:0] OP_CLR   = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_TURN} state_t;

   state_t state, state_nxt;

   logic [1:0]       q_op  [FIFO_DEPTH];
   logic [SEL_W-1:0] q_src [FIFO_DEPTH];
   logic [SEL_W-1:0] q_dst [FIFO_DEPTH];
   logic [7:0]       q_imm [FIFO_DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             full, empty, push, pop;

   logic [1:0]        h_op;
   logic [SEL_W-1:0]  h_src, h_dst;
   logic [7:0]        h_imm;
   logic [N_REGS-1:0] h_src_oh, h_dst_oh;
   logic              h_legal;

   logic [N_REGS-1:0] rd_q, wr_q, clr_q, rd_nxt, wr_nxt, clr_nxt;
   logic              drive_q, done_q, err_q, ill_q;
   logic              drive_nxt, done_nxt, err_nxt, ill_nxt;
   logic [7:0]        imm_q;

   // Decodes an index to a one-hot strobe; indices outside the register set give all zeros.
   function automatic logic [N_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot = '0;
      for (int i = 0; i < N_REGS; i++)
         if (idx == SEL_W'(i)) onehot[i] = 1'b1;
   endfunction

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign push  = ifc.cmd_valid && !full;
   assign pop   = (state == S_IDLE) && !empty;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_op [wptr[AW-1:0]] <= ifc.cmd_op;
         q_src[wptr[AW-1:0]] <= ifc.cmd_src;
         q_dst[wptr[AW-1:0]] <= ifc.cmd_dst;
         q_imm[wptr[AW-1:0]] <= ifc.cmd_imm;
      end
   end

   assign h_op     = q_op [rptr[AW-1:0]];
   assign h_src    = q_src[rptr[AW-1:0]];
   assign h_dst    = q_dst[rptr[AW-1:0]];
   assign h_imm    = q_imm[rptr[AW-1:0]];
   assign h_src_oh = onehot(h_src);
   assign h_dst_oh = onehot(h_dst);

   always_comb begin
      h_legal = 1'b1;
      case (h_op)
         OP_MOVE:          h_legal = (h_src != h_dst) && (|h_src_oh) && (|h_dst_oh);
         OP_LOADI, OP_CLR: h_legal = |h_dst_oh;
         default:          h_legal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!empty) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_TURN;
         S_TURN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Strobes are computed at the pop and registered so they cover exactly the EXEC cycle.
   always_comb begin
      rd_nxt    = '0;
      wr_nxt    = '0;
      clr_nxt   = '0;
      drive_nxt = 1'b0;
      if (pop && h_legal) begin
         case (h_op)
            OP_MOVE: begin
               rd_nxt = h_src_oh;
               wr_nxt = h_dst_oh;
            end
            OP_LOADI: begin
               wr_nxt    = h_dst_oh;
               drive_nxt = 1'b1;
            end
            OP_CLR:  clr_nxt = h_dst_oh;
            OP_NOP:  ;
            default: ;
         endcase
      end
      ill_nxt  = pop ? !h_legal : ill_q;
      done_nxt = (state == S_EXEC);
      err_nxt  = (state == S_EXEC) && ill_q;
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         rd_q    <= '0;
         wr_q    <= '0;
         clr_q   <= '0;
         drive_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         rd_q    <= rd_nxt;
         wr_q    <= wr_nxt;
         clr_q   <= clr_nxt;
         drive_q <= drive_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
         ill_q   <= ill_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) imm_q <= h_imm;
   end

   assign ifc.cmd_ready = !full;
   assign ifc.rd_en     = rd_q;
   assign ifc.wr_en     = wr_q;
   assign ifc.clr       = clr_q;
   assign ifc.done      = done_q;
   assign ifc.err       = err_q;
   assign ifc.busy      = (state != S_IDLE) || !empty;
   assign bus_out       = drive_q ? imm_q : 8'bzzzzzzzz;
endmodule
